mem_modport: RTL and testbench
==============================

// Module: mem_modport
// PURPOSE
//  Single-port 32x8 synchronous memory, the slave side of the mem_ifa interface (mem modport).
//  Writes and reads are captured on the rising clock edge. Read data is registered.
//  Sits behind the mem_test driver, which performs write_mem/read_mem transactions.
// PARAMETERS
//  ADDR_WIDTH  5  address width; depth = 2**ADDR_WIDTH (32 words)
//  DATA_WIDTH  8  word width in bits
// PORTS
//  clk       input   1   clock; all state updates on posedge
//  reset     input   1   synchronous, active-high reset
//  read      input   1   read strobe, sampled at posedge
//  write     input   1   write strobe, sampled at posedge
//  addr      input   5   word address for read and write
//  data_in   input   8   write data
//  data_out  output  8   registered read data
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high. Reset has no effect between edges.
//  - Reset (posedge, reset=1):
//     - all 32 words are cleared to 8'h00;
//     - data_out is cleared to 8'h00;
//     - read and write are ignored that cycle.
//  - Write (reset=0, write=1): mem[addr] <= data_in at the posedge. No acknowledge. Single-cycle.
//  - Read (reset=0, read=1): data_out <= mem[addr] at the posedge.
//     - Latency 1 cycle: data is valid after that edge, so a reader may sample it ~1 time unit later.
//  - Idle (read=0): data_out holds its last value. Memory is unchanged when write=0.
//  - Simultaneous read=1 and write=1:
//     - the write always commits;
//     - data_out returns the OLD mem[addr] (read-before-write), unless MEM_BYPASS_EN is defined.
//  - Addresses are full-range 0..31. There is no out-of-range case and no wrap logic.
//  - X/Z on strobes: treated as 0 (no operation); in simulation an $error is emitted.
//  - Arithmetic: none. Words are stored and returned verbatim, unsigned, full width.
// CONFIGURATION
//  MEM_BYPASS_EN defined:
//    simultaneous read+write to the same addr returns data_in on data_out (write-through forwarding).
//  MEM_BYPASS_EN undefined:
//    data_out returns the pre-write contents.
//  All other behaviour is identical in both builds.
// STRUCTURE
//  - Package mem_pkg holds:
//     - ADDR_WIDTH, DATA_WIDTH, DEPTH constants;
//     - typedef addr_t = logic [ADDR_WIDTH-1:0];
//     - typedef data_t = logic [DATA_WIDTH-1:0].
//  - One sub-module mem_array: the storage array with write port and read mux.
//  - The top level adds the data_out register, reset sequencing and the bypass mux.
// TESTING
//  1. Reset then read all 32 addresses -> every data_out == 8'h00.
//  2. Write data=addr to addr 0..31, then read 0..31 -> data_out == addr each time, one cycle after the read edge.
//  3. Write addr 5 = 8'hA5, hold read=0 for 3 cycles -> data_out unchanged; then read addr 5 -> 8'hA5.
//  4. addr 7 holds 8'h11; on the same edge read=1, write=1, data_in=8'h22 to addr 7:
//     -> data_out == 8'h11 without MEM_BYPASS_EN, 8'h22 with it; a following read of addr 7 returns 8'h22 in both builds.
//  5. Fill memory, assert reset for one cycle while write=1 -> no write occurs, all words and data_out == 8'h00.
//  6. Write 8'hFF to addr 31 and 8'h00 to addr 0, read both back -> 8'hFF and 8'h00 (full-width, boundary addresses).
//  Pass/fail is reported via printstatus(error_count).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and word/address types for the 32x8 memory slice.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/mem_array.sv
// Storage array for mem_modport: synchronous clear, single write port,
// combinational read mux (returns the contents before any same-edge write).
import mem_pkg::*;

module mem_array (
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  addr_t addr,
  input  data_t wdata,
  output data_t rdata
);

  data_t mem [DEPTH];

  // Synchronous clear of every word; otherwise commit the write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Asynchronous read mux of the current (pre-edge) contents.
  always_comb begin
    rdata = mem[addr];
  end

endmodule

// File: rtl/mem_modport.sv
// Single-port 32x8 synchronous memory, slave side of the mem interface.
// Registered read data, read-before-write on a simultaneous read/write.
// Build option: define MEM_BYPASS_EN to forward data_in to data_out when
// read and write hit the same edge (write-through forwarding).
import mem_pkg::*;

module mem_modport (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  data_t array_rdata;
  data_t read_value;

  mem_array u_array (
    .clk   (clk),
    .reset (reset),
    .we    (write),
    .addr  (addr),
    .wdata (data_in),
    .rdata (array_rdata)
  );

  // Select what a read returns this edge: stored word, or forwarded write data.
  always_comb begin
    read_value = array_rdata;
`ifdef MEM_BYPASS_EN
    if (write) begin
      read_value = data_in;
    end
`endif
  end

  // Registered read data; holds its value when no read is strobed.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= read_value;
    end
  end

`ifndef SYNTHESIS
  // Unknown strobes already fall through as no-ops above; flag them loudly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({read, write}))
        else $error("mem_modport: unknown read/write strobe");
    end
  end
`endif

endmodule

// File: tb/tb_mem_modport.sv
// Self-checking bench for mem_modport: directed scenarios followed by random
// traffic, all checked against an array-based reference model.
// Define MEM_BYPASS_EN here as for the RTL to check the forwarding build.
module tb_mem_modport;
  import mem_pkg::*;

  logic  clk = 1'b0;
  logic  reset, read, write;
  addr_t addr;
  data_t data_in;
  data_t data_out;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: plain array plus expected registered output.
  data_t model_mem [DEPTH];
  data_t exp_out;
  bit    model_valid = 1'b0;

`ifdef MEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  mem_modport dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input data_t act, input data_t req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: data_out=%02h required=%02h at %0t", name, act, req, $time);
  endtask

  // One bus cycle: drive, take the edge, advance the model by the rules.
  task automatic cyc(input bit rst, input bit rd, input bit wr,
                     input addr_t a, input data_t d);
    reset = rst; read = rd; write = wr; addr = a; data_in = d;
    @(posedge clk);
    if (rst) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      exp_out = '0;
      model_valid = 1'b1;
    end else begin
      if (rd) exp_out = (wr && BYPASS) ? d : model_mem[a];
      if (wr) model_mem[a] = d;
    end
    #1;
  endtask

  // Every-cycle compare against the model once it is defined.
  always @(negedge clk) begin
    if (model_valid) check("model", data_out, exp_out);
  end

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    @(negedge clk);

    // 1: reset, then every word reads as zero
    cyc(1, 0, 0, 0, 0);
    check("reset_out", data_out, 8'h00);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0, addr_t'(i), 0);
      check("reset_word", data_out, 8'h00);
    end

    // 2: data = addr pattern
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, addr_t'(i), data_t'(i));
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0, addr_t'(i), 0);
      check("addr_pattern", data_out, data_t'(i));
    end

    // 3: idle holds output, then read back
    cyc(0, 0, 1, 5, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, addr_t'($urandom_range(31)), 8'($urandom));
      check("idle_hold", data_out, 8'd31);
    end
    cyc(0, 1, 0, 5, 0);
    check("read_a5", data_out, 8'hA5);

    // 4: simultaneous read and write
    cyc(0, 0, 1, 7, 8'h11);
    cyc(0, 1, 1, 7, 8'h22);
    check("rw_same_edge", data_out, BYPASS ? 8'h22 : 8'h11);
    cyc(0, 1, 0, 7, 0);
    check("rw_after", data_out, 8'h22);

    // 5: reset wins over a concurrent write
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, addr_t'(i), 8'hC0 | data_t'(i));
    cyc(0, 1, 0, 3, 0);
    check("fill_read", data_out, 8'hC3);
    cyc(1, 1, 1, 9, 8'h5A);
    check("reset_vs_write", data_out, 8'h00);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0, addr_t'(i), 0);
      check("reset_clears", data_out, 8'h00);
    end

    // 6: full-width data at boundary addresses
    cyc(0, 0, 1, 31, 8'hFF);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 31, 0);
    check("addr31_ff", data_out, 8'hFF);
    cyc(0, 1, 0, 0, 0);
    check("addr0_00", data_out, 8'h00);

    // Random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(99) == 0), $urandom_range(1), $urandom_range(1),
          addr_t'($urandom_range(31)), 8'($urandom));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
